// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// Frame layout is start bit (0), DATA_W data bits LSB-first, an optional
// parity bit, and a stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
// The serial line is driven from a flop so it never glitches with tx_data.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic PAR_ON  = (PARITY_EN != 0);
    localparam logic PAR_INV = (ODD_PARITY != 0);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              parity_bit;
    logic              bit_end;

    // Handshake and status flags decode straight from the state register.
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // End of the current bit period; with CLKS_PER_BIT=1 this is always true.
    assign bit_end    = (cnt == CNT_LAST);
    assign shift_next = shift_reg >> 1;

    // Frame sequencer: tx_out is loaded with the value of the state being
    // entered, so the line changes exactly on the state transition edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_out     <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shift_reg  <= tx_data;
                        parity_bit <= (^tx_data) ^ PAR_INV;
                        bit_idx    <= '0;
                        tx_out     <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        tx_out  <= shift_reg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_LAST) begin
                            if (PAR_ON) begin
                                tx_out <= parity_bit;
                                state  <= PARITY;
                            end else begin
                                tx_out <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_next;
                            tx_out    <= shift_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_out <= 1'b1;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_out <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed bench for serial_frame_tx. Four instances run
// side by side from the same inputs: default, odd parity, no parity and
// one clock per bit, so one stimulus sequence covers every variant.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] ready;
    logic [3:0] line;
    logic [3:0] bsy;
    logic [3:0] dn;

    int checks = 0;
    int errors = 0;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .ODD_PARITY(0)) u_def (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready[0]), .tx_out(line[0]), .busy(bsy[0]), .done(dn[0]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .ODD_PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready[1]), .tx_out(line[1]), .busy(bsy[1]), .done(dn[1]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .ODD_PARITY(0)) u_nopar (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready[2]), .tx_out(line[2]), .busy(bsy[2]), .done(dn[2]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .ODD_PARITY(0)) u_fast (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready[3]), .tx_out(line[3]), .busy(bsy[3]), .done(dn[3]));

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word, input logic valid);
        tx_data  = word;
        tx_valid = valid;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for frame bit index idx (1 past the frame = idle).
    function automatic logic expBit(input logic [7:0] w, input logic odd, input logic par, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (par && idx == 9) return (^w) ^ odd;
        return 1'b1;
    endfunction

    // Check every instance at cycle c counted from the first START cycle.
    task automatic sampleCycle(input int c, input logic [7:0] w, input bit all);
        if (c < 44) begin
            checkOutput($sformatf("def_out@%0d", c), 32'(line[0]), 32'(expBit(w, 1'b0, 1'b1, c / 4)));
            checkOutput($sformatf("def_ready@%0d", c), 32'(ready[0]), 32'd0);
            checkOutput($sformatf("def_busy@%0d", c), 32'(bsy[0]), 32'd1);
            checkOutput($sformatf("def_done@%0d", c), 32'(dn[0]), 32'd0);
        end else begin
            checkOutput($sformatf("def_out@%0d", c), 32'(line[0]), 32'd1);
            checkOutput($sformatf("def_ready@%0d", c), 32'(ready[0]), 32'd1);
            checkOutput($sformatf("def_done@%0d", c), 32'(dn[0]), (c == 44) ? 32'd1 : 32'd0);
        end
        if (all) begin
            checkOutput($sformatf("odd_out@%0d", c), 32'(line[1]),
                        (c < 44) ? 32'(expBit(w, 1'b1, 1'b1, c / 4)) : 32'd1);
            checkOutput($sformatf("odd_done@%0d", c), 32'(dn[1]), (c == 44) ? 32'd1 : 32'd0);
            checkOutput($sformatf("nopar_out@%0d", c), 32'(line[2]), 32'(expBit(w, 1'b0, 1'b0, c / 4)));
            checkOutput($sformatf("nopar_done@%0d", c), 32'(dn[2]), (c == 40) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fast_out@%0d", c), 32'(line[3]), 32'(expBit(w, 1'b0, 1'b1, c)));
            checkOutput($sformatf("fast_done@%0d", c), 32'(dn[3]), (c == 11) ? 32'd1 : 32'd0);
        end
    endtask

    // Send one word from idle and follow all instances through done.
    task automatic runFrame(input logic [7:0] w);
        applyStimulus(w, 1'b1);
        tick();
        applyStimulus(w, 1'b0);
        for (int c = 0; c <= 45; c++) begin
            sampleCycle(c, w, 1'b1);
            if (c < 45) tick();
        end
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(8'h00, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Asynchronous reset with a pending word: nothing may start.
        applyStimulus(8'hA5, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("rst_out", 32'(line), 32'hF);
        checkOutput("rst_ready", 32'(ready), 32'hF);
        checkOutput("rst_busy", 32'(bsy), 32'h0);
        checkOutput("rst_done", 32'(dn), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rst_hold_busy%0d", i), 32'(bsy), 32'h0);
            checkOutput($sformatf("rst_hold_out%0d", i), 32'(line), 32'hF);
        end
        applyStimulus(8'h00, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("post_rst_busy", 32'(bsy), 32'h0);

        // Single frames, covering even/odd/no parity and one clock per bit.
        runFrame(8'hA5);
        runFrame(8'h01);

        // Back-to-back with tx_valid held: 0x3C then 0xFF on the default instance.
        $display("[TB] back-to-back");
        applyStimulus(8'h3C, 1'b1);
        tick();
        applyStimulus(8'hFF, 1'b1);
        for (int c = 0; c <= 44; c++) begin
            sampleCycle(c, 8'h3C, 1'b0);
            tick();
        end
        applyStimulus(8'hFF, 1'b0);
        for (int c = 0; c <= 45; c++) begin
            sampleCycle(c, 8'hFF, 1'b0);
            if (c < 45) tick();
        end
        pulseReset();

        // Word and valid changing while busy must not disturb the frame.
        $display("[TB] data change while busy");
        applyStimulus(8'h81, 1'b1);
        tick();
        applyStimulus(8'h81, 1'b0);
        for (int c = 0; c <= 45; c++) begin
            if (c == 5) applyStimulus(8'h00, 1'b1);
            if (c == 20) applyStimulus(8'h00, 1'b0);
            sampleCycle(c, 8'h81, 1'b0);
            if (c < 45) tick();
        end
        pulseReset();

        // Abort during data bit 3 of 0x55, then a clean 0x0F frame.
        $display("[TB] abort mid-frame");
        applyStimulus(8'h55, 1'b1);
        tick();
        applyStimulus(8'h55, 1'b0);
        for (int c = 0; c <= 17; c++) begin
            sampleCycle(c, 8'h55, 1'b1);
            if (c < 17) tick();
        end
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_out", 32'(line), 32'hF);
        checkOutput("abort_busy", 32'(bsy), 32'h0);
        checkOutput("abort_ready", 32'(ready), 32'hF);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("abort_nodone%0d", i), 32'(dn), 32'h0);
            checkOutput($sformatf("abort_idle%0d", i), 32'(line), 32'hF);
        end
        runFrame(8'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
